// File: rtl/dc_ipu_filter_pkg.sv
// Shared constants and width helpers for the weighted-sum texel filter.
package dc_ipu_filter_pkg;

   localparam int unsigned NUM_CHANNELS = 3;
   localparam int unsigned PIPE_LATENCY = 3;

   // 16 products of CW-bit unsigned by WW-bit signed, summed without overflow.
   function automatic int unsigned acc_width(input int unsigned cw, input int unsigned ww);
      return cw + ww + 5;
   endfunction

endpackage

// File: rtl/dc_ipu_filter_channel_dot.sv
// One colour channel of the 4x4 weighted sum: S1 products, S2 row sums, S3 round and range.
// DC_IPU_FILTER_CLAMP_EN selects saturation to [0, 2^CW-1]; otherwise the result wraps.
module dc_ipu_filter_channel_dot
   import dc_ipu_filter_pkg::*;
#(
   parameter int unsigned CHAN_WIDTH         = 8,
   parameter int unsigned WEIGHT_WIDTH       = 12,
   parameter int unsigned WEIGHT_FRACT_WIDTH = 8
) (
   input  logic                                   clk,
   input  logic                                   nreset,
   input  logic                                   en,
   input  logic [0:3][0:3][CHAN_WIDTH-1:0]        texels,
   input  logic [0:3][0:3][WEIGHT_WIDTH-1:0]      weights,
   output logic [CHAN_WIDTH-1:0]                  res
);

   localparam int unsigned PW = CHAN_WIDTH + WEIGHT_WIDTH + 1;
   localparam int unsigned RW = PW + 2;
   localparam int unsigned AW = acc_width(CHAN_WIDTH, WEIGHT_WIDTH);
   localparam logic signed [AW-1:0] RoundBias = AW'(1) <<< (WEIGHT_FRACT_WIDTH - 1);

   logic signed [PW-1:0] prod_d [4][4];
   logic signed [PW-1:0] prod_q [4][4];
   logic signed [RW-1:0] row_d  [4];
   logic signed [RW-1:0] row_q  [4];
   logic signed [AW-1:0] total;
   logic signed [AW-1:0] rounded;
   logic [CHAN_WIDTH-1:0] res_d;
   logic [CHAN_WIDTH-1:0] res_q;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            // Texel is unsigned: prepend a zero so the signed multiply treats it as positive.
            prod_d[i][j] = PW'($signed({1'b0, texels[i][j]})) * PW'($signed(weights[i][j]));
         end
         row_d[i] = RW'(prod_q[i][0]) + RW'(prod_q[i][1]) + RW'(prod_q[i][2]) + RW'(prod_q[i][3]);
      end
   end

   always_comb begin
      total   = AW'(row_q[0]) + AW'(row_q[1]) + AW'(row_q[2]) + AW'(row_q[3]);
      rounded = (total + RoundBias) >>> WEIGHT_FRACT_WIDTH;
`ifdef DC_IPU_FILTER_CLAMP_EN
      if (rounded < 0) begin
         res_d = '0;
      end else if (rounded > AW'((1 << CHAN_WIDTH) - 1)) begin
         res_d = '1;
      end else begin
         res_d = rounded[CHAN_WIDTH-1:0];
      end
`else
      res_d = rounded[CHAN_WIDTH-1:0];
`endif
   end

`ifndef DC_IPU_FILTER_CLAMP_EN
   logic unused_rounded_hi;
   assign unused_rounded_hi = ^rounded[AW-1:CHAN_WIDTH];
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < 4; i++) begin
            row_q[i] <= '0;
            for (int j = 0; j < 4; j++) begin
               prod_q[i][j] <= '0;
            end
         end
         res_q <= '0;
      end else if (en) begin
         for (int i = 0; i < 4; i++) begin
            row_q[i] <= row_d[i];
            for (int j = 0; j < 4; j++) begin
               prod_q[i][j] <= prod_d[i][j];
            end
         end
         res_q <= res_d;
      end
   end

   assign res = res_q;

endmodule

// File: rtl/dc_ipu_filter_weighted_sum.sv
// 3-stage 4x4 weighted-sum filter over packed {R,G,B} texels with valid/ready handshake.
// Build with DC_IPU_FILTER_CLAMP_EN to saturate channels instead of wrapping.
module dc_ipu_filter_weighted_sum
   import dc_ipu_filter_pkg::*;
#(
   parameter int unsigned RGB_WIDTH          = 24,
   parameter int unsigned WEIGHT_FRACT_WIDTH = 8,
   parameter int unsigned WEIGHT_WIDTH       = 12
) (
   input  logic                                        clk,
   input  logic                                        nreset,
   input  logic                                        clr,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic        [0:3][0:3][RGB_WIDTH-1:0]       in_texel_matrix,
   input  logic signed [0:3][0:3][WEIGHT_WIDTH-1:0]    weights_matrix,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic        [RGB_WIDTH-1:0]                 out_pixel
);

   localparam int unsigned CW = RGB_WIDTH / NUM_CHANNELS;

   logic                    en;
   logic [PIPE_LATENCY-1:0] valid_q;

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign out_valid = valid_q[PIPE_LATENCY-1];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q <= '0;
      end else if (clr) begin
         valid_q <= '0;
      end else if (en) begin
         valid_q <= {valid_q[PIPE_LATENCY-2:0], in_valid};
      end
   end

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      // Channel 0 is R, held in the most significant bits.
      localparam int unsigned Lsb = (NUM_CHANNELS - 1 - c) * CW;

      logic [0:3][0:3][CW-1:0] ch_tex;

      always_comb begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
               ch_tex[i][j] = in_texel_matrix[i][j][Lsb +: CW];
            end
         end
      end

      dc_ipu_filter_channel_dot #(
         .CHAN_WIDTH         (CW),
         .WEIGHT_WIDTH       (WEIGHT_WIDTH),
         .WEIGHT_FRACT_WIDTH (WEIGHT_FRACT_WIDTH)
      ) u_dot (
         .clk     (clk),
         .nreset  (nreset),
         .en      (en),
         .texels  (ch_tex),
         .weights (weights_matrix),
         .res     (out_pixel[Lsb +: CW])
      );
   end

endmodule

// File: tb/tb_dc_ipu_filter_weighted_sum.sv
// Randomised and directed bench for dc_ipu_filter_weighted_sum with a queue scoreboard.
module tb_dc_ipu_filter_weighted_sum;

   typedef logic        [0:3][0:3][23:0] tex_t;
   typedef logic signed [0:3][0:3][11:0] w_t;

   logic        clk = 1'b0;
   logic        nreset;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   tex_t        in_tex;
   w_t          in_w;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_pixel;

   int          n_checks    = 0;
   int          n_errors    = 0;
   int          n_delivered = 0;
   int          ready_mode  = 0;
   logic [23:0] exp_q[$];

   dc_ipu_filter_weighted_sum #(
      .RGB_WIDTH          (24),
      .WEIGHT_FRACT_WIDTH (8),
      .WEIGHT_WIDTH       (12)
   ) dut (
      .clk             (clk),
      .nreset          (nreset),
      .clr             (clr),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_texel_matrix (in_tex),
      .weights_matrix  (in_w),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pixel       (out_pixel)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: integer dot product per channel, round half-up, then clamp or wrap.
   function automatic logic [23:0] model(input tex_t t, input w_t w);
      logic [23:0] px;
      longint      acc;
      longint      r;
      px = '0;
      for (int c = 0; c < 3; c++) begin
         acc = 0;
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
               acc += longint'(t[i][j][(2-c)*8 +: 8]) * longint'($signed(w[i][j]));
            end
         end
         r = (acc + 128) >>> 8;
`ifdef DC_IPU_FILTER_CLAMP_EN
         if (r < 0) r = 0;
         else if (r > 255) r = 255;
`endif
         px[(2-c)*8 +: 8] = r[7:0];
      end
      return px;
   endfunction

   function automatic tex_t fill_tex(input logic [23:0] v);
      tex_t t;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) t[i][j] = v;
      return t;
   endfunction

   function automatic tex_t one_tex(input int i, input int j, input logic [23:0] v);
      tex_t t;
      t = '0;
      t[i][j] = v;
      return t;
   endfunction

   function automatic w_t one_w(input int i, input int j, input int v);
      w_t w;
      w = '0;
      w[i][j] = 12'(v);
      return w;
   endfunction

   function automatic w_t fill_w(input int v);
      w_t w;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) w[i][j] = 12'(v);
      return w;
   endfunction

   function automatic tex_t rand_tex();
      tex_t t;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) t[i][j] = 24'($urandom);
      return t;
   endfunction

   function automatic w_t rand_w();
      w_t w;
      bit wide;
      wide = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (wide) w[i][j] = 12'($urandom);
            else      w[i][j] = 12'(int'($urandom_range(0, 160)) - 64);
         end
      end
      return w;
   endfunction

   // Consumer: 0 always ready, 1 stalled, otherwise random.
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Scoreboard sampled on the falling edge, ahead of the rising edge that acts on it.
   always @(negedge clk) begin
      if (!nreset) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               check_eq("out_pixel", 32'(out_pixel), 32'(exp_q.pop_front()));
               n_delivered++;
            end
         end
         if (clr) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back(model(in_tex, in_w));
      end
   end

   task automatic set_mode(input int m);
      ready_mode = m;
      @(posedge clk);
   endtask

   // Starts at a rising edge; returns at the rising edge that accepted the beat.
   task automatic send_beat(input tex_t t, input w_t w);
      bit done;
      done = 1'b0;
      #2;
      in_tex   = t;
      in_w     = w;
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
      end
      if (!done) check_eq("accept_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic idle(input int n);
      #2;
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic run_directed(input string tag, input tex_t t, input w_t w,
                               input logic [23:0] exp);
      int lat;
      send_beat(t, w);
      #2;
      in_valid = 1'b0;
      lat = 1;
      while (lat < 10) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      check_eq({tag, "_latency"}, 32'(lat), 32'd3);
      check_eq(tag, 32'(out_pixel), 32'(exp));
      @(posedge clk);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
      check_eq(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      nreset   = 1'b1;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_tex   = '0;
      in_w     = '0;
      #3 nreset = 1'b0;
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_pixel", 32'(out_pixel), 32'd0);
      repeat (2) @(posedge clk);
      #2 nreset = 1'b1;
      #1 check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      set_mode(0);

      run_directed("identity", one_tex(1, 1, 24'h123456), one_w(1, 1, 256), 24'h123456);
      run_directed("uniform", fill_tex(24'h808080), fill_w(16), 24'h808080);
      run_directed("half_round", fill_tex(24'h010101), one_w(2, 2, 128), 24'h010101);
`ifdef DC_IPU_FILTER_CLAMP_EN
      run_directed("negative", one_tex(0, 0, 24'hFFFFFF), one_w(0, 0, -256), 24'h000000);
      run_directed("overshoot", one_tex(1, 1, 24'hC0C0C0), one_w(1, 1, 512), 24'hFFFFFF);
`else
      run_directed("negative", one_tex(0, 0, 24'hFFFFFF), one_w(0, 0, -256), 24'h010101);
      run_directed("overshoot", one_tex(1, 1, 24'hC0C0C0), one_w(1, 1, 512), 24'h808080);
`endif

      // Backpressure: three back-to-back beats held behind a stalled consumer.
      set_mode(1);
      d0 = n_delivered;
      for (int b = 0; b < 3; b++) send_beat(rand_tex(), rand_w());
      #2 in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
         check_eq("stall_out_valid", 32'(out_valid), 32'd1);
         check_eq("stall_hold", 32'(out_pixel), 32'(exp_q.size() != 0 ? exp_q[0] : 24'h0));
      end
      set_mode(0);
      drain("stall_drain");
      check_eq("stall_delivered", 32'(n_delivered - d0), 32'd3);

      // Clear with two beats in flight and a third offered during the clear.
      for (int b = 0; b < 2; b++) send_beat(rand_tex(), rand_w());
      #2;
      in_tex = rand_tex();
      clr    = 1'b1;
      @(posedge clk);
      #2;
      clr      = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq("clr_no_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);

      // Reset with a stalled, full pipeline.
      set_mode(1);
      for (int b = 0; b < 3; b++) send_beat(fill_tex(24'h404040), fill_w(16));
      idle(1);
      #2 nreset = 1'b0;
      #1;
      check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
      check_eq("midrst_out_pixel", 32'(out_pixel), 32'd0);
      @(posedge clk);
      #2 nreset = 1'b1;
      set_mode(0);
      run_directed("post_reset", one_tex(3, 3, 24'h0A0B0C), one_w(3, 3, 256), 24'h0A0B0C);

      // Random traffic with random consumer stalls and input bubbles.
      set_mode(2);
      d0 = n_delivered;
      for (int b = 0; b < 300; b++) begin
         send_beat(rand_tex(), rand_w());
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);
      set_mode(0);
      drain("random_drain");
      check_eq("random_delivered", 32'(n_delivered - d0), 32'd300);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dc_ipu_filter_weighted_sum.md
DC_IPU_FILTER_WEIGHTED_SUM -- requirements
Module: dc_ipu_filter_weighted_sum

Interface
REQ-001 SHALL have parameter RGB_WIDTH, default 24, meaning packed texel width of three equal channels {R,G,B}, R in the MSBs.
REQ-002 SHALL have parameter WEIGHT_FRACT_WIDTH, default 8, meaning fractional bits of each weight (1.0 = 2^WEIGHT_FRACT_WIDTH).
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 12, meaning signed two's-complement weight width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous clear; empties the pipeline.
REQ-007 SHALL have port in_valid  input  1  input beat present.
REQ-008 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_texel_matrix  input  RGB_WIDTH x [0:3][0:3]  4x4 source texels.
REQ-010 SHALL have port weights_matrix  input  signed WEIGHT_WIDTH x [0:3][0:3]  per-texel 2D weights.
REQ-011 SHALL have port out_valid  output  1  filtered pixel present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 SHALL have port out_pixel  output  RGB_WIDTH  filtered packed pixel.

Function
REQ-014 SHALL, per channel c, compute acc = sum over i,j of unsigned texel[i][j].c times signed weights_matrix[i][j], signed, width CW+WEIGHT_WIDTH+5 (CW = RGB_WIDTH/3); never overflows.
REQ-015 SHALL round half-up: res = (acc + 2^(WEIGHT_FRACT_WIDTH-1)) arithmetic-shifted right by WEIGHT_FRACT_WIDTH.
REQ-016 SHALL be a 3-stage pipeline: S1 16 products/channel registered, S2 four row sums registered, S3 total+round+range handling registered; accepted beat appears on out_pixel exactly 3 cycles later when unstalled.
REQ-017 SHALL use a single advance enable en = !out_valid || out_ready; in_ready = en; all stages, including per-stage valid bits, advance only when en.
REQ-018 SHALL allow bubbles: a stage loads valid=0 when the previous stage is empty; one beat per cycle sustained throughput.
REQ-019 SHALL hold out_pixel and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL, on clr, zero all stage valid bits next cycle regardless of en; data registers need not clear; the input beat offered that cycle is discarded.
REQ-021 SHALL deliver beats in acceptance order, none lost or duplicated.

Reset
REQ-022 SHALL, on nreset low, asynchronously drive out_valid=0, all stage valid bits=0, out_pixel=0; in_ready=1 once nreset is high.
REQ-023 SHALL discard beats in flight when reset is asserted mid-operation; first accepted beat after release emerges 3 cycles later.

Configuration
REQ-024 SHALL, with DC_IPU_FILTER_CLAMP_EN defined, saturate each channel res to [0, 2^CW-1].
REQ-025 SHALL, without DC_IPU_FILTER_CLAMP_EN, output the low CW bits of res (wrap), saving comparators.

Structure
REQ-026 SHALL take from package dc_ipu_filter_pkg: accumulator-width function, channel-count constant (3), pipeline-latency constant (3).
REQ-027 SHALL instantiate sub-module dc_ipu_filter_channel_dot three times (one per channel), holding S1-S3 datapath; valid/enable logic stays in the top.

Verification (RGB_WIDTH=24, WEIGHT_WIDTH=12, WEIGHT_FRACT_WIDTH=8)
REQ-028 SHALL cover identity: w[1][1]=256, others 0, t[1][1]=0x123456 -> out_pixel 0x123456, out_valid 3 cycles after accept.
REQ-029 SHALL cover rounding/uniform: all w=16, all t=0x808080 -> 0x808080; single w[2][2]=128, t=0x010101 -> 0x010101.
REQ-030 SHALL cover negative: w[0][0]=-256, t[0][0]=0xFFFFFF -> 0x000000 with clamp, 0x010101 without.
REQ-031 SHALL cover overshoot: w[1][1]=512, t[1][1]=0xC0C0C0 -> 0xFFFFFF with clamp, 0x808080 without.
REQ-032 SHALL cover backpressure: 3 back-to-back beats, out_ready low 5 cycles -> in_ready low while stalled, output held, all 3 delivered in order.
REQ-033 SHALL cover clr and reset mid-stream: 2 beats in flight, clr pulse -> no out_valid from them; nreset pulse -> out_valid=0 and out_pixel=0 immediately.
